truth_table_sweeper: RTL and testbench

- Sequencing controller for an N-input single-output combinational logic function block, such as the synthesized 4-input truth-table gates.
- On `start`, it drives every input combination in ascending order and waits a programmable settle time per combination.
- It samples the function output, assembles the captured truth table and compares it against an expected table.
- It sits between the test/characterisation controller and the gate under evaluation.

---
 rtl/truth_table_sweeper.sv | 125 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Sweeps every input combination of an N-input function block, samples its output
// after a settle delay, and compares the captured truth table against an expected one.
module truth_table_sweeper #(
  parameter int N_INPUTS      = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [2**N_INPUTS-1:0]   expected,
  output logic [N_INPUTS-1:0]      fn_in,
  input  logic                     fn_out,
  output logic                     busy,
  output logic                     done,
  output logic                     match,
  output logic [2**N_INPUTS-1:0]   captured,
  output logic [N_INPUTS-1:0]      first_bad
);

  localparam int TW = 2**N_INPUTS;
  localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("truth_table_sweeper: SETTLE_CYCLES must be at least 1");
    end
  endgenerate

  logic [1:0]          state;
  logic [N_INPUTS-1:0] idx;
  logic [CW-1:0]       cnt;
  logic [TW-1:0]       exp_q;
  logic [TW-1:0]       cap_nxt;
  logic [TW-1:0]       diff;
  logic [N_INPUTS-1:0] fb_nxt;

  // Table as it will look after the current sample, so the verdict in FINISH
  // already includes the final combination.
  always_comb begin
    cap_nxt      = captured;
    cap_nxt[idx] = fn_out;
    diff         = cap_nxt ^ exp_q;
    fb_nxt       = '0;
    for (int k = TW - 1; k >= 0; k--)
      if (diff[k]) fb_nxt = N_INPUTS'(k);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      exp_q     <= '0;
      fn_in     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      match     <= 1'b0;
      captured  <= '0;
      first_bad <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            exp_q    <= expected;
            captured <= '0;
            idx      <= '0;
            cnt      <= '0;
            match    <= 1'b0;
            fn_in    <= '0;
            busy     <= 1'b1;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (abort) begin
            state <= IDLE;
            fn_in <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state <= IDLE;
            fn_in <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            captured <= cap_nxt;
            if (idx == {N_INPUTS{1'b1}}) begin
              state     <= FINISH;
              busy      <= 1'b0;
              done      <= 1'b1;
              match     <= (cap_nxt == exp_q);
              first_bad <= fb_nxt;
              fn_in     <= '0;
            end else begin
              idx   <= idx + 1'b1;
              fn_in <= idx + 1'b1;
              cnt   <= '0;
              state <= DRIVE;
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: table of full sweeps plus abort, reset,
// start-spam and a SETTLE_CYCLES=1 instance.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        reset, start, abort, start2;
  logic [15:0] exp_tt, gate;
  logic [3:0]  fn_in1, fn_in2, fb1, fb2;
  logic        fn_out1, busy1, busy2, done1, done2, match1, match2;
  logic [15:0] cap1, cap2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Behavioural gate under evaluation: output is its table bit at the driven index.
  assign fn_out1 = gate[fn_in1];

  truth_table_sweeper #(.N_INPUTS(4), .SETTLE_CYCLES(2)) u0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .expected(exp_tt),
    .fn_in(fn_in1), .fn_out(fn_out1), .busy(busy1), .done(done1), .match(match1),
    .captured(cap1), .first_bad(fb1));

  truth_table_sweeper #(.N_INPUTS(4), .SETTLE_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort), .expected(exp_tt),
    .fn_in(fn_in2), .fn_out(1'b0), .busy(busy2), .done(done2), .match(match2),
    .captured(cap2), .first_bad(fb2));

  typedef struct {
    logic [15:0] g;
    logic [15:0] e;
    logic [15:0] cap;
    bit          m;
    logic [3:0]  fb;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic run_sweep(input bit sel, input logic [15:0] g, input logic [15:0] e,
                           input logic [15:0] ecap, input bit em, input logic [3:0] efb,
                           input bit spam, input string nm);
    int s, dcyc, ndone, seqerr;
    logic [3:0] fi;
    logic       bz, dn;
    s = sel ? 1 : 2;
    @(negedge clk);
    gate = g; exp_tt = e;
    if (sel) start2 = 1'b1; else start = 1'b1;
    dcyc = -1; ndone = 0; seqerr = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      start  = spam && !sel && (cyc % 7 == 0) && (cyc < 45);
      start2 = 1'b0;
      fi = sel ? fn_in2 : fn_in1;
      bz = sel ? busy2 : busy1;
      dn = sel ? done2 : done1;
      if (cyc <= 16 * (s + 1)) begin
        if (fi != 4'((cyc - 1) / (s + 1)) || !bz) seqerr++;
      end else if (fi != 4'd0 || bz) begin
        seqerr++;
      end
      if (dn) begin
        ndone++;
        if (dcyc < 0) dcyc = cyc;
      end
    end
    check({nm, " seq"}, 32'(seqerr), 32'd0);
    check({nm, " done_cycle"}, 32'(dcyc), 32'(16 * (s + 1) + 1));
    check({nm, " done_count"}, 32'(ndone), 32'd1);
    check({nm, " captured"}, 32'(sel ? cap2 : cap1), 32'(ecap));
    check({nm, " match"}, 32'(sel ? match2 : match1), 32'(em));
    check({nm, " first_bad"}, 32'(sel ? fb2 : fb1), 32'(efb));
  endtask

  initial begin
    int  ndone;
    bit  found;
    vecs[0] = '{16'h6900, 16'h6900, 16'h6900, 1'b1, 4'd0};
    vecs[1] = '{16'h6900, 16'h6908, 16'h6900, 1'b0, 4'd3};
    vecs[2] = '{16'h8001, 16'h0001, 16'h8001, 1'b0, 4'd15};
    vecs[3] = '{16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b1, 4'd0};
    vecs[4] = '{16'h0000, 16'h0100, 16'h0000, 1'b0, 4'd8};

    reset = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0;
    exp_tt = '0; gate = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst fn_in", 32'(fn_in1), 32'd0);
    check("rst busy", 32'(busy1), 32'd0);
    check("rst done", 32'(done1), 32'd0);
    check("rst match", 32'(match1), 32'd0);
    check("rst captured", 32'(cap1), 32'd0);
    check("rst first_bad", 32'(fb1), 32'd0);
    reset = 1'b0;

    // start together with abort must be ignored
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start+abort busy", 32'(busy1), 32'd0);

    for (int i = 0; i < 5; i++)
      run_sweep(1'b0, vecs[i].g, vecs[i].e, vecs[i].cap, vecs[i].m, vecs[i].fb, 1'b0,
                $sformatf("vec%0d", i));

    // abort at index 5
    gate = 16'h0015; exp_tt = 16'h0015; start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (fn_in1 == 4'd5) found = 1'b1;
    end
    check("abort reached idx5", 32'(found), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", 32'(busy1), 32'd0);
    check("abort fn_in", 32'(fn_in1), 32'd0);
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      if (done1) ndone++;
      @(negedge clk);
    end
    check("abort no done", 32'(ndone), 32'd0);
    check("abort captured", 32'(cap1), 32'h0015);
    check("abort match", 32'(match1), 32'd0);
    run_sweep(1'b0, 16'h6900, 16'h6900, 16'h6900, 1'b1, 4'd0, 1'b0, "post_abort");

    // repeated start during a sweep: no restart, one done
    run_sweep(1'b0, 16'h6900, 16'h6908, 16'h6900, 1'b0, 4'd3, 1'b1, "spam");

    // reset at index 10
    gate = 16'h6900; exp_tt = 16'h6900; start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (fn_in1 == 4'd10) found = 1'b1;
    end
    check("reset reached idx10", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst fn_in", 32'(fn_in1), 32'd0);
    check("midrst busy", 32'(busy1), 32'd0);
    check("midrst done", 32'(done1), 32'd0);
    check("midrst match", 32'(match1), 32'd0);
    check("midrst captured", 32'(cap1), 32'd0);
    check("midrst first_bad", 32'(fb1), 32'd0);
    reset = 1'b0;
    run_sweep(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 4'd0, 1'b0, "all_ones");

    // SETTLE_CYCLES=1 instance, output tied low
    run_sweep(1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 4'd0, 1'b0, "settle1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
